// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - WIDTH-bit D register, write enable, async active-low reset; optional clear (D_FLIP_FLOP_CLEAR_EN)
// Also holds the legacy wrappers register_32, register_5 and D_FlipFlop (positional q, d, write, reset, clk).

module d_flip_flop #(
    parameter int unsigned WIDTH     = 1,
    parameter logic [63:0] RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef D_FLIP_FLOP_CLEAR_EN
    ,
    input  logic             clear
`endif
);

    localparam logic [WIDTH-1:0] W_RESET_Q = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    logic             w_clear;

`ifdef D_FLIP_FLOP_CLEAR_EN
    assign w_clear = clear;
`else
    assign w_clear = 1'b0;
`endif

    // Priority: reset > clear > write > hold (bubble insertion reuses the reset value).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= W_RESET_Q;
        end else if (w_clear) begin
            r_q <= W_RESET_Q;
        end else if (write) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

module register_32 (
    output logic [31:0] q,
    input  logic [31:0] d,
    input  logic        write,
    input  logic        reset,
    input  logic        clk
);

    d_flip_flop #(.WIDTH(32)) u_ff (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .d     (d),
        .q     (q)
`ifdef D_FLIP_FLOP_CLEAR_EN
        ,
        .clear (1'b0)
`endif
    );

endmodule

module register_5 (
    output logic [4:0] q,
    input  logic [4:0] d,
    input  logic       write,
    input  logic       reset,
    input  logic       clk
);

    d_flip_flop #(.WIDTH(5)) u_ff (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .d     (d),
        .q     (q)
`ifdef D_FLIP_FLOP_CLEAR_EN
        ,
        .clear (1'b0)
`endif
    );

endmodule

module D_FlipFlop (
    output logic [0:0] q,
    input  logic [0:0] d,
    input  logic       write,
    input  logic       reset,
    input  logic       clk
);

    d_flip_flop #(.WIDTH(1)) u_ff (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .d     (d),
        .q     (q)
`ifdef D_FLIP_FLOP_CLEAR_EN
        ,
        .clear (1'b0)
`endif
    );

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - scoreboard bench for d_flip_flop and its legacy wrappers
module tb_d_flip_flop;

`ifdef D_FLIP_FLOP_CLEAR_EN
    localparam bit HAS_CLR = 1'b1;
`else
    localparam bit HAS_CLR = 1'b0;
`endif

    // 0:u32 1:u5 2:u1 3:uff 4:reg32 5:reg5 6:dff1 ; wrappers share inputs of 0/1/2
    localparam int          WID [7] = '{32, 5, 1, 32, 32, 5, 1};
    localparam logic [63:0] RV  [7] = '{64'h0, 64'h15, 64'h1, 64'hFFFF_FFFF, 64'h0, 64'h0, 64'h0};
    string NM [7] = '{"u32", "u5", "u1", "uff", "reg32", "reg5", "dff1"};

    typedef struct {
        int          idx;
        logic [63:0] exp;
        int          due;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  wr = 4'b0;
    logic [63:0] din [4];
    logic [31:0] q0;
    logic [4:0]  q1;
    logic [0:0]  q2;
    logic [31:0] q3;
    logic [31:0] q4;
    logic [4:0]  q5;
    logic [0:0]  q6;

    logic [63:0] m [7];
    chk_t        sb [$];
    int          tick = 0;
    int          n_pass = 0;
    int          n_total = 0;
    event        sample_ev;

    always #5 clk = ~clk;

    d_flip_flop #(.WIDTH(32), .RESET_VAL(64'h0)) u32 (
        .clk(clk), .reset(reset), .write(wr[0]), .d(din[0][31:0]), .q(q0)
`ifdef D_FLIP_FLOP_CLEAR_EN
        , .clear(clr)
`endif
    );
    d_flip_flop #(.WIDTH(5), .RESET_VAL(64'h1_0000_0015)) u5 (
        .clk(clk), .reset(reset), .write(wr[1]), .d(din[1][4:0]), .q(q1)
`ifdef D_FLIP_FLOP_CLEAR_EN
        , .clear(clr)
`endif
    );
    d_flip_flop #(.WIDTH(1), .RESET_VAL(64'h3)) u1 (
        .clk(clk), .reset(reset), .write(wr[2]), .d(din[2][0:0]), .q(q2)
`ifdef D_FLIP_FLOP_CLEAR_EN
        , .clear(clr)
`endif
    );
    d_flip_flop #(.WIDTH(32), .RESET_VAL(64'hFFFF_FFFF)) uff (
        .clk(clk), .reset(reset), .write(wr[3]), .d(din[3][31:0]), .q(q3)
`ifdef D_FLIP_FLOP_CLEAR_EN
        , .clear(clr)
`endif
    );

    register_32 u_r32 (q4, din[0][31:0], wr[0], reset, clk);
    register_5  u_r5  (q5, din[1][4:0], wr[1], reset, clk);
    D_FlipFlop  u_r1  (q6, din[2][0:0], wr[2], reset, clk);

    function automatic logic [63:0] mask_of(input int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] get_q(input int i);
        case (i)
            0:       return {32'd0, q0};
            1:       return {59'd0, q1};
            2:       return {63'd0, q2};
            3:       return {32'd0, q3};
            4:       return {32'd0, q4};
            5:       return {59'd0, q5};
            default: return {63'd0, q6};
        endcase
    endfunction

    task automatic push_all(input int due);
        for (int i = 0; i < 7; i++) sb.push_back('{idx: i, exp: m[i], due: due});
    endtask

    // Reference rule for the edge that follows: what q must hold afterwards.
    task automatic model_edge();
        for (int i = 0; i < 7; i++) begin
            int s;
            s = (i < 4) ? i : i - 4;
            if (!reset)                           m[i] = RV[i];
            else if (HAS_CLR && i < 4 && clr)     m[i] = RV[i];
            else if (wr[s])                       m[i] = din[s] & mask_of(WID[i]);
        end
        push_all(tick + 1);
    endtask

    task automatic step(input logic rst_v, input logic clr_v, input logic [3:0] wv,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [63:0] d3);
        @(negedge clk);
        reset = rst_v;
        clr = clr_v;
        wr = wv;
        din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
        if (!rst_v) for (int i = 0; i < 7; i++) m[i] = RV[i];
        model_edge();
    endtask

    // Mid-cycle reset change, checked before the next clock edge.
    task automatic async_rst(input logic v);
        @(negedge clk);
        #2;
        reset = v;
        if (!v) for (int i = 0; i < 7; i++) m[i] = RV[i];
        push_all(tick);
        #1;
        ->sample_ev;
        model_edge();
    endtask

    always begin
        @(posedge clk);
        #1;
        tick = tick + 1;
        ->sample_ev;
    end

    initial begin
        forever begin
            @(sample_ev);
            while (sb.size() > 0 && sb[0].due <= tick) begin
                chk_t        c;
                logic [63:0] act;
                c = sb.pop_front();
                act = get_q(c.idx);
                n_total++;
                if (act === c.exp) n_pass++;
                else $display("FAIL %s tick=%0d actual=%h required=%h", NM[c.idx], tick, act, c.exp);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) din[i] = 64'd0;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 7; i++) m[i] = RV[i];
        push_all(tick);
        #1;
        ->sample_ev;
        model_edge();

        step(1'b0, 1'b0, 4'hF, 64'h1234_5678, 64'h1F, 64'h0, 64'h0);
        async_rst(1'b1);
        step(1'b1, 1'b0, 4'hF, 64'h4, 64'h5, 64'h1, 64'h0);

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'b0000, 64'h0, 64'd17, 64'h0, 64'h0);
        step(1'b1, 1'b0, 4'b0010, 64'h0, 64'd17, 64'h0, 64'h0);

        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 4'b0100, 64'h0, 64'h0, 64'(k & 1), 64'h0);

        step(1'b1, 1'b0, 4'b1001, 64'hDEAD_BEEF, 64'h0, 64'h0, 64'h0);
        async_rst(1'b0);
        step(1'b0, 1'b0, 4'hF, 64'hDEAD_BEEF, 64'h3, 64'h1, 64'h5);
        async_rst(1'b1);

        step(1'b1, 1'b0, 4'b0010, 64'h0, 64'd9, 64'h0, 64'h0);
        step(1'b1, 1'b1, 4'b0010, 64'h0, 64'd3, 64'h0, 64'h0);
        step(1'b1, 1'b0, 4'b0010, 64'h0, 64'd3, 64'h0, 64'h0);

        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                async_rst(1'b0);
                async_rst(1'b1);
            end else begin
                step((r >= 95) ? 1'b0 : 1'b1, ($urandom_range(0, 9) == 0), 4'($urandom),
                     {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, {$urandom, $urandom});
            end
        end

        step(1'b1, 1'b0, 4'b0000, 64'h0, 64'h0, 64'h0, 64'h0);
        repeat (2) @(negedge clk);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d required=0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
